// File: rtl/conv_window_streamer_pkg.sv
// Shared types and widths for the 3x3-window pixel streamer.
package conv_window_streamer_pkg;

    localparam int PIXEL_WIDTH_OUT = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROW_START,
        ST_READ,
        ST_FLUSH,
        ST_ROW_GAP,
        ST_DRAIN
    } streamer_state_t;

endpackage

// File: rtl/conv_window_streamer_if.sv
// Pixel/result link between the window streamer and the convolution controller.
interface conv_window_streamer_if;
    import conv_window_streamer_pkg::*;

    logic                       start_cnn_o;
    logic [PIXEL_WIDTH_OUT-1:0] px_o;
    logic                       px_rdy_o;
    logic                       res_rdy_i;

    modport master (output start_cnn_o, px_o, px_rdy_o, input res_rdy_i);
    modport slave  (input start_cnn_o, px_o, px_rdy_o, output res_rdy_i);

endinterface

// File: rtl/conv_window_streamer_px_addr_gen.sv
// Walks the column vectors of one window row; row bases advance by IMG_W
// through accumulation so no multiplier is needed.
module conv_window_streamer_px_addr_gen #(
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int ADDR_W = $clog2(IMG_W*IMG_H)
) (
    input  logic              clk_i,
    input  logic              nreset_i,
    input  logic              clear_i,
    input  logic              step_i,
    input  logic              next_row_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              row_last_o,
    output logic              frame_last_o
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int WY_W  = $clog2(IMG_H);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(IMG_W);

    logic [WY_W-1:0]   wy_q, wy_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [1:0]        elem_q, elem_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    assign row_last_o   = (elem_q == 2'd2) && (col_q == COL_W'(IMG_W-1));
    assign frame_last_o = row_last_o && (wy_q == WY_W'(IMG_H-3));
    assign addr_o       = addr_q;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            wy_q       <= '0;
            col_q      <= '0;
            elem_q     <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
        end else begin
            wy_q       <= wy_d;
            col_q      <= col_d;
            elem_q     <= elem_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
        end
    end

    // NOTE: every variable gets a hold default first, so no path infers a latch.
    always_comb begin
        wy_d       = wy_q;
        col_d      = col_q;
        elem_d     = elem_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        if (clear_i) begin
            wy_d       = '0;
            col_d      = '0;
            elem_d     = '0;
            row_base_d = '0;
            addr_d     = '0;
        end else if (next_row_i) begin
            wy_d       = wy_q + 1'b1;
            col_d      = '0;
            elem_d     = '0;
            row_base_d = row_base_q + STRIDE;
            addr_d     = row_base_q + STRIDE;
        end else if (step_i && !row_last_o) begin
            // The final read of a row holds position; next_row or clear follows.
            if (elem_q == 2'd2) begin
                elem_d = '0;
                col_d  = col_q + 1'b1;
                addr_d = row_base_q + ADDR_W'(col_q) + 1'b1;
            end else begin
                elem_d = elem_q + 1'b1;
                addr_d = addr_q + STRIDE;
            end
        end
    end

endmodule

// File: rtl/conv_window_streamer.sv
// Transmit side of the serial 3x3-window pixel protocol: streams column vectors
// from a synchronous frame memory and counts the returned convolution results.
module conv_window_streamer
    import conv_window_streamer_pkg::*;
#(
    parameter int IMG_W   = 16,
    parameter int IMG_H   = 16,
    parameter int ADDR_W  = $clog2(IMG_W*IMG_H),
    parameter int PX_GAP  = 0,
    parameter int ROW_GAP = 2
) (
    input  logic                       clk_i,
    input  logic                       nreset_i,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       mem_rd_o,
    output logic [ADDR_W-1:0]          mem_addr_o,
    input  logic [PIXEL_WIDTH_OUT-1:0] mem_data_i,
    output logic                       frame_done_o,
    conv_window_streamer_if.master     cnn
);
    localparam int TOTAL  = (IMG_W-2)*(IMG_H-2);
    localparam int RES_W  = $clog2(TOTAL+1);
    localparam int WAIT_W = $clog2(PX_GAP+ROW_GAP+3);

    streamer_state_t            state_q, state_d;
    logic [WAIT_W-1:0]          wait_q, wait_d;
    logic [RES_W-1:0]           res_cnt_q, res_cnt_d;
    logic                       start_cnn_q, start_cnn_d;
    logic [PIXEL_WIDTH_OUT-1:0] px_q, px_d;
    logic                       rd_dly_q, px_rdy_q;
    logic                       clear, next_row, row_last, frame_last, res_done;

    conv_window_streamer_px_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .clk_i       (clk_i),
        .nreset_i    (nreset_i),
        .clear_i     (clear),
        .step_i      (mem_rd_o),
        .next_row_i  (next_row),
        .addr_o      (mem_addr_o),
        .row_last_o  (row_last),
        .frame_last_o(frame_last)
    );

    assign res_done        = (res_cnt_q == RES_W'(TOTAL));
    assign cnn.start_cnn_o = start_cnn_q;
    assign cnn.px_o        = px_q;
    assign cnn.px_rdy_o    = px_rdy_q;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            res_cnt_q   <= '0;
            start_cnn_q <= 1'b0;
            px_q        <= '0;
            rd_dly_q    <= 1'b0;
            px_rdy_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            res_cnt_q   <= res_cnt_d;
            start_cnn_q <= start_cnn_d;
            px_q        <= px_d;
            rd_dly_q    <= mem_rd_o;
            px_rdy_q    <= rd_dly_q;
        end
    end

    // wait_q paces reads in READ and times the FLUSH and ROW_GAP intervals.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        res_cnt_d = res_cnt_q;
        if (state_q != ST_IDLE && cnn.res_rdy_i) res_cnt_d = res_cnt_q + 1'b1;
        case (state_q)
            ST_IDLE: if (start_i) begin
                state_d   = ST_ROW_START;
                res_cnt_d = '0;
            end
            ST_ROW_START: begin
                state_d = ST_READ;
                wait_d  = '0;
            end
            ST_READ: if (wait_q == '0) begin
                if (row_last) begin
                    state_d = ST_FLUSH;
                    wait_d  = WAIT_W'(1);
                end else begin
                    wait_d = WAIT_W'(PX_GAP);
                end
            end else begin
                wait_d = wait_q - 1'b1;
            end
            ST_FLUSH: if (wait_q == '0) begin
                if (frame_last) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_ROW_GAP;
                    wait_d  = WAIT_W'(ROW_GAP-1);
                end
            end else begin
                wait_d = wait_q - 1'b1;
            end
            ST_ROW_GAP: if (wait_q == '0) state_d = ST_ROW_START;
                        else wait_d = wait_q - 1'b1;
            ST_DRAIN: if (res_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // start_cnn is registered, so it stays high through the last FLUSH cycle
    // in which the row's final pixel is presented.
    always_comb begin
        busy_o       = (state_q != ST_IDLE);
        mem_rd_o     = (state_q == ST_READ) && (wait_q == '0);
        clear        = (state_q == ST_IDLE) && start_i;
        next_row     = (state_q == ST_ROW_GAP) && (wait_q == '0);
        start_cnn_d  = (state_q inside {ST_ROW_START, ST_READ, ST_FLUSH});
        frame_done_o = (state_q == ST_DRAIN) && res_done;
        px_d         = rd_dly_q ? mem_data_i : px_q;
    end

endmodule
